// File: rtl/ddr3_bclk_train_pkg.sv
// Shared types and constants for the DDR3 BCLK-training controller and its tap sampler.
package ddr3_bclk_train_pkg;

  localparam int TAP_W_DEFAULT = 7;

  localparam logic [7:0] BAD_PATTERN_ZERO = 8'h00;
  localparam logic [7:0] BAD_PATTERN_ONES = 8'hFF;

  localparam logic DIR_INC = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_SETTLE = 4'd2,
    ST_SAMPLE = 4'd3,
    ST_EVAL   = 4'd4,
    ST_STEP   = 4'd5,
    ST_DECIDE = 4'd6,
    ST_CENTER = 4'd7,
    ST_DONE   = 4'd8,
    ST_FAIL   = 4'd9
  } train_state_t;

  // A stuck-low or stuck-high BCLK word means the sampler is not seeing edges at all.
  function automatic logic is_bad_pattern(input logic [7:0] word);
    return (word == BAD_PATTERN_ZERO) || (word == BAD_PATTERN_ONES);
  endfunction

endpackage

// File: rtl/ddr3_bclk_tap_sampler.sv
// SAMPLE-phase comparator: after a start pulse, inspects SAMPLE_CYCLES RX words and
// reports whether the current tap saw one constant, toggling pattern with no eye flags.
module ddr3_bclk_tap_sampler
  import ddr3_bclk_train_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_rx_data,
  input  logic       i_eye_early,
  input  logic       i_eye_late,
  output logic       o_done,
  output logic       o_stable
);

  localparam int CNT_W = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_word0;
  logic             r_ok;
  logic             r_done;
  logic             r_stable;

  logic w_flags;
  logic w_cycle_ok;
  logic w_ok_next;

  assign w_flags    = i_eye_early | i_eye_late;
  assign w_cycle_ok = (r_cnt == '0) ? (!is_bad_pattern(i_rx_data) && !w_flags)
                                    : ((i_rx_data == r_word0) && !w_flags);
  assign w_ok_next  = (r_cnt == '0) ? w_cycle_ok : (r_ok && w_cycle_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_word0  <= '0;
      r_ok     <= 1'b0;
      r_done   <= 1'b0;
      r_stable <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
      end else if (r_active) begin
        if (r_cnt == '0) r_word0 <= i_rx_data;
        r_ok <= w_ok_next;
        // The verdict is registered together with done so the controller sees both at once.
        if (r_cnt == CNT_LAST) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
          r_stable <= w_ok_next;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_done   = r_done;
  assign o_stable = r_stable;

endmodule

// File: rtl/ddr3_bclk_training_ctrl.sv
// DDR3 BCLK-training controller: sweeps the IOD RX delay line, finds the longest stable
// window and parks at its centre. Define BCLK_TRAIN_DEBUG_EN to expose window/state debug.
module ddr3_bclk_training_ctrl
  import ddr3_bclk_train_pkg::*;
#(
  parameter int NUM_TAPS      = 128,
  parameter int TAP_W         = TAP_W_DEFAULT,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_WINDOW    = 8
) (
  input  logic             i_fab_clk,
  input  logic             i_sync_rst,
  input  logic             i_start,
  input  logic [7:0]       i_rx_data,
  input  logic             i_eye_monitor_early,
  input  logic             i_eye_monitor_late,
  input  logic             i_delay_line_out_of_range,
  output logic             o_delay_line_load,
  output logic             o_delay_line_move,
  output logic             o_delay_line_direction,
  output logic             o_eye_monitor_clear_flags,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fail,
  output logic [TAP_W-1:0] o_tap_out
`ifdef BCLK_TRAIN_DEBUG_EN
  ,
  output logic [TAP_W-1:0] o_dbg_win_start,
  output logic [TAP_W:0]   o_dbg_win_len,
  output logic [3:0]       o_dbg_state
`endif
);

  localparam int LEN_W  = TAP_W + 1;
  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [TAP_W-1:0]  TAP_LAST    = TAP_W'(NUM_TAPS - 1);
  localparam logic [LEN_W-1:0]  MIN_LEN     = LEN_W'(MIN_WINDOW);
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SETTLE_CLR  = SCNT_W'(SETTLE_CYCLES - 2);

  train_state_t      r_state;
  logic [SCNT_W-1:0] r_settle_cnt;
  logic [TAP_W-1:0]  r_cur_tap;
  logic [TAP_W-1:0]  r_run_start;
  logic [LEN_W-1:0]  r_run_len;
  logic [TAP_W-1:0]  r_best_start;
  logic [LEN_W-1:0]  r_best_len;
  logic [LEN_W-1:0]  r_tgt;
  logic              r_phase;
  logic              r_tap_stable;
  logic              r_dl_load;
  logic              r_dl_move;
  logic              r_eye_clr;
  logic              r_busy;
  logic              r_done;
  logic              r_fail;
  logic [TAP_W-1:0]  r_tap_out;

  logic             w_smp_start;
  logic             w_smp_done;
  logic             w_smp_stable;
  logic [LEN_W-1:0] w_run_len_inc;
  logic [TAP_W-1:0] w_run_start_next;
  logic             w_best_upd;
  logic [LEN_W-1:0] w_center_sum;

  assign w_smp_start      = (r_state == ST_SETTLE) && (r_settle_cnt == SETTLE_LAST);
  assign w_run_len_inc    = r_run_len + 1'b1;
  assign w_run_start_next = (r_run_len == '0) ? r_cur_tap : r_run_start;
  // Best is refreshed while a run grows, so an open run is already closed when the sweep ends.
  assign w_best_upd       = r_tap_stable && (w_run_len_inc > r_best_len);
  assign w_center_sum     = {1'b0, r_best_start} + (r_best_len >> 1);

  ddr3_bclk_tap_sampler #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_sampler (
    .i_clk       (i_fab_clk),
    .i_rst       (i_sync_rst),
    .i_start     (w_smp_start),
    .i_rx_data   (i_rx_data),
    .i_eye_early (i_eye_monitor_early),
    .i_eye_late  (i_eye_monitor_late),
    .o_done      (w_smp_done),
    .o_stable    (w_smp_stable)
  );

  always_ff @(posedge i_fab_clk) begin
    if (i_sync_rst) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_cur_tap    <= '0;
      r_run_start  <= '0;
      r_run_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
      r_tgt        <= '0;
      r_phase      <= 1'b0;
      r_tap_stable <= 1'b0;
      r_dl_load    <= 1'b0;
      r_dl_move    <= 1'b0;
      r_eye_clr    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_tap_out    <= '0;
    end else begin
      r_dl_load <= 1'b0;
      r_dl_move <= 1'b0;
      r_eye_clr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_dl_load    <= 1'b1;
          r_cur_tap    <= '0;
          r_run_start  <= '0;
          r_run_len    <= '0;
          r_best_start <= '0;
          r_best_len   <= '0;
          r_settle_cnt <= '0;
          r_state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_eye_clr <= (r_settle_cnt == SETTLE_CLR);
          if (r_settle_cnt == SETTLE_LAST) begin
            r_settle_cnt <= '0;
            r_state      <= ST_SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (w_smp_done) begin
            r_tap_stable <= w_smp_stable;
            r_state      <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (r_tap_stable) begin
            r_run_len   <= w_run_len_inc;
            r_run_start <= w_run_start_next;
          end else begin
            r_run_len <= '0;
          end
          if (w_best_upd) begin
            r_best_len   <= w_run_len_inc;
            r_best_start <= w_run_start_next;
          end
          if ((r_cur_tap == TAP_LAST) || i_delay_line_out_of_range) r_state <= ST_DECIDE;
          else                                                      r_state <= ST_STEP;
        end
        ST_STEP: begin
          r_dl_move    <= 1'b1;
          r_cur_tap    <= r_cur_tap + 1'b1;
          r_settle_cnt <= '0;
          r_state      <= ST_SETTLE;
        end
        ST_DECIDE: begin
          if (r_best_len < MIN_LEN) begin
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_FAIL;
          end else begin
            r_tgt     <= w_center_sum;
            r_dl_load <= 1'b1;
            r_cur_tap <= '0;
            r_phase   <= 1'b0;
            r_state   <= ST_CENTER;
          end
        end
        // Alternating phase keeps MOVE off the LOAD cycle and spaces pulses two cycles apart.
        ST_CENTER: begin
          if (i_delay_line_out_of_range) begin
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_FAIL;
          end else if ({1'b0, r_cur_tap} == r_tgt) begin
            r_tap_out <= r_cur_tap;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_DONE;
          end else if (r_phase) begin
            r_dl_move <= 1'b1;
            r_cur_tap <= r_cur_tap + 1'b1;
            r_phase   <= 1'b0;
          end else begin
            r_phase <= 1'b1;
          end
        end
        ST_DONE, ST_FAIL: begin
          if (i_start) begin
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BCLK_TRAIN_DEBUG_EN
  logic [TAP_W-1:0] r_dbg_win_start;
  logic [LEN_W-1:0] r_dbg_win_len;

  always_ff @(posedge i_fab_clk) begin
    if (i_sync_rst) begin
      r_dbg_win_start <= '0;
      r_dbg_win_len   <= '0;
    end else if (r_state == ST_LOAD) begin
      r_dbg_win_start <= '0;
      r_dbg_win_len   <= '0;
    end else if ((r_state == ST_EVAL) && w_best_upd) begin
      r_dbg_win_start <= w_run_start_next;
      r_dbg_win_len   <= w_run_len_inc;
    end
  end

  assign o_dbg_win_start = r_dbg_win_start;
  assign o_dbg_win_len   = r_dbg_win_len;
  assign o_dbg_state     = r_state;
`endif

  assign o_delay_line_load         = r_dl_load;
  assign o_delay_line_move         = r_dl_move;
  assign o_delay_line_direction    = DIR_INC;
  assign o_eye_monitor_clear_flags = r_eye_clr;
  assign o_busy                    = r_busy;
  assign o_done                    = r_done;
  assign o_fail                    = r_fail;
  assign o_tap_out                 = r_tap_out;

endmodule
